// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and helpers for the multi-key debouncer.
//   key_state_t  : per-channel debounce FSM state encoding
//   prescale_tc  : terminal count of the shared sample-tick prescaler
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // The prescaler counts 0..tc and fires the tick on tc, so the tick
    // period is exactly f_clk/f_tick clock cycles.
    function automatic int prescale_tc(input int f_clk, input int f_tick);
        return (f_clk / f_tick) - 1;
    endfunction

endpackage

// File: rtl/multi_key_debouncer_if.sv
// -----------------------------------------------------------------------------
// multi_key_debouncer_if
// Bundle of raw key inputs and debounced level/event outputs.
//   i_key       : raw asynchronous key levels (driven by the board side)
//   key_state   : debounced level, 1 = pressed
//   key_press   : one-cycle pulse on debounced press
//   key_release : one-cycle pulse on debounced release
//   key_long    : one-cycle pulse after a long hold, at most once per press
// Modports:
//   slave  : the debouncer (consumes i_key, produces the key_* outputs)
//   master : the board/consumer side (drives i_key, observes key_*)
// -----------------------------------------------------------------------------
interface multi_key_debouncer_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] i_key;
    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;

    modport slave (
        input  i_key,
        output key_state,
        output key_press,
        output key_release,
        output key_long
    );

    modport master (
        output i_key,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long
    );
endinterface

// File: rtl/key_channel.sv
// -----------------------------------------------------------------------------
// key_channel
// One debounced key: 2-FF synchronizer, polarity normalisation, debounce FSM,
// debounce and long-press counters, and registered level/event outputs.
// Ports:
//   clk_i     : system clock
//   rst_ni    : asynchronous active-low reset
//   tick_i    : shared one-cycle sample strobe; the FSM only moves on it
//   key_i     : raw asynchronous key level
//   state_o   : debounced level, 1 = pressed
//   press_o   : one-cycle pulse on debounced press
//   release_o : one-cycle pulse on debounced release
//   long_o    : one-cycle pulse when the hold reaches LONG_TICKS
// -----------------------------------------------------------------------------
module key_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter int ACTIVE_LOW     = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic key_i,
    output logic state_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int CNT_W  = $clog2(DEBOUNCE_TICKS + 1);
    localparam int LCNT_W = $clog2(LONG_TICKS + 1);

    localparam logic              IDLE_LEVEL = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DEB_LAST   = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [LCNT_W-1:0] LONG_LAST  = LCNT_W'(LONG_TICKS);

    logic              sync1_q, sync2_q;
    logic              act;
    key_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d, lcnt_inc;
    logic              state_out_q, state_out_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              was_pressed;

    // The synchronizer resets to the released level so a key that is held
    // through reset is seen as a fresh press afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    assign act      = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    assign cnt_inc  = cnt_q + CNT_ONE;
    assign lcnt_inc = lcnt_q + LCNT_W'(1);

    // State, counters and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lcnt_q      <= '0;
            state_out_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lcnt_q      <= lcnt_d;
            state_out_q <= state_out_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    // Next-state logic. The first sample that sees the key active already
    // counts as one, so PRESSED is reached on the DEBOUNCE_TICKS-th
    // consecutive active sample. lcnt survives a bounce through
    // RELEASE_WAIT so a saturated counter cannot fire key_long again.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lcnt_d  = lcnt_q;
        if (tick_i) begin
            unique case (state_q)
                IDLE: begin
                    if (act) begin
                        if (DEBOUNCE_TICKS == 1) begin
                            state_d = PRESSED;
                            cnt_d   = '0;
                            lcnt_d  = '0;
                        end else begin
                            state_d = PRESS_WAIT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!act) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == DEB_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        lcnt_d  = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                PRESSED: begin
                    if (act) begin
                        if (lcnt_q != LONG_LAST) begin
                            lcnt_d = lcnt_inc;
                        end
                    end else if (DEBOUNCE_TICKS == 1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (act) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_inc == DEB_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the transition about to be taken; the results are
    // registered so level and pulses change on the same edge as the state.
    always_comb begin
        was_pressed = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
        state_out_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        press_d     = state_out_d && !was_pressed;
        release_d   = was_pressed && !state_out_d;
        long_d      = (lcnt_d == LONG_LAST) && (lcnt_q != LONG_LAST);
    end

    assign state_o   = state_out_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: rtl/multi_key_debouncer.sv
// -----------------------------------------------------------------------------
// multi_key_debouncer
// N-channel push-button debouncer with press/release/long-press events.
// A single prescaler produces a one-cycle sample tick shared by every channel.
// Ports:
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : slave side of multi_key_debouncer_if (raw keys in,
//             debounced level and event pulses out)
// -----------------------------------------------------------------------------
module multi_key_debouncer
    import debounce_pkg::*;
#(
    parameter int F_CLK          = 50000000,
    parameter int F_TICK         = 1000,
    parameter int N_KEYS         = 4,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000,
    parameter int ACTIVE_LOW     = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    multi_key_debouncer_if.slave   bus
);

    localparam int PS_TC = prescale_tc(F_CLK, F_TICK);
    localparam int PS_W  = (PS_TC > 0) ? $clog2(PS_TC + 1) : 1;

    // Parameter sanity checks, evaluated at elaboration.
    if (DEBOUNCE_TICKS < 1) begin : g_chk_deb
        $error("DEBOUNCE_TICKS must be at least 1");
    end
    if (LONG_TICKS <= DEBOUNCE_TICKS) begin : g_chk_long
        $error("LONG_TICKS must exceed DEBOUNCE_TICKS");
    end
    if ((F_CLK / F_TICK) < 2) begin : g_chk_div
        $error("F_CLK/F_TICK must be at least 2");
    end

    logic [PS_W-1:0]   ps_q, ps_d;
    logic              tick;
    logic [N_KEYS-1:0] state_vec, press_vec, release_vec, long_vec;

    assign tick = (ps_q == PS_W'(PS_TC));
    assign ps_d = tick ? '0 : ps_q + PS_W'(1);

    // Shared prescaler: free-running, wraps at the terminal count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_chan
        key_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .LONG_TICKS     (LONG_TICKS),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_chan (
            .clk_i     (i_clk),
            .rst_ni    (i_rst_n),
            .tick_i    (tick),
            .key_i     (bus.i_key[k]),
            .state_o   (state_vec[k]),
            .press_o   (press_vec[k]),
            .release_o (release_vec[k]),
            .long_o    (long_vec[k])
        );
    end

    assign bus.key_state   = state_vec;
    assign bus.key_press   = press_vec;
    assign bus.key_release = release_vec;
    assign bus.key_long    = long_vec;

endmodule

// File: tb/tb_multi_key_debouncer.sv
// -----------------------------------------------------------------------------
// tb_multi_key_debouncer
// Directed bench for multi_key_debouncer with a 10-cycle sample tick,
// 2 keys, 3-tick debounce and 10-tick long press, active-low keys.
// Cycle numbers count rising edges since reset release; the first tick is
// sampled on edge 10 and every 10th edge after that.
// -----------------------------------------------------------------------------
module tb_multi_key_debouncer;

    localparam int N = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    multi_key_debouncer_if #(.N_KEYS(N)) bus ();

    multi_key_debouncer #(
        .F_CLK          (1000),
        .F_TICK         (100),
        .N_KEYS         (N),
        .DEBOUNCE_TICKS (3),
        .LONG_TICKS     (10),
        .ACTIVE_LOW     (1)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   press_n[N], release_n[N], long_n[N];
    int   press_at[N], release_at[N], long_at[N];
    logic press_state[N];

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic clear_counts();
        for (int k = 0; k < N; k++) begin
            press_n[k] = 0; release_n[k] = 0; long_n[k] = 0;
            press_at[k] = -1; release_at[k] = -1; long_at[k] = -1;
            press_state[k] = 1'b0;
        end
    endtask

    // Advance one clock and log any event pulses seen 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (bus.key_press[k] === 1'b1) begin
                press_n[k]++; press_at[k] = cyc; press_state[k] = bus.key_state[k];
            end
            if (bus.key_release[k] === 1'b1) begin
                release_n[k]++; release_at[k] = cyc;
            end
            if (bus.key_long[k] === 1'b1) begin
                long_n[k]++; long_at[k] = cyc;
            end
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic hold_reset(input logic [1:0] keys);
        rst_n     = 1'b0;
        bus.i_key = keys;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        cyc   = 0;
        clear_counts();
    endtask

    task automatic test_reset();
        hold_reset(2'b11);
        checks++; if (bus.key_state !== 2'b00) begin errors++; $display("[TB] FAIL reset_state: got %b expected 00", bus.key_state); end
        checks++; if (bus.key_press !== 2'b00) begin errors++; $display("[TB] FAIL reset_press: got %b expected 00", bus.key_press); end
        checks++; if (bus.key_release !== 2'b00) begin errors++; $display("[TB] FAIL reset_release: got %b expected 00", bus.key_release); end
        checks++; if (bus.key_long !== 2'b00) begin errors++; $display("[TB] FAIL reset_long: got %b expected 00", bus.key_long); end
        release_reset();
        run_to(8);
        checks++; if (dut.tick !== 1'b0) begin errors++; $display("[TB] FAIL tick_early: got %b expected 0 at cycle 8", dut.tick); end
        run_to(9);
        checks++; if (dut.tick !== 1'b1) begin errors++; $display("[TB] FAIL tick_first: got %b expected 1 at cycle 9", dut.tick); end
        run_to(10);
        checks++; if (dut.tick !== 1'b0) begin errors++; $display("[TB] FAIL tick_width: got %b expected 0 at cycle 10", dut.tick); end
    endtask

    task automatic test_clean_press();
        hold_reset(2'b11);
        release_reset();
        bus.i_key = 2'b10;
        run_to(29);
        checks++; if (press_n[0] !== 0) begin errors++; $display("[TB] FAIL clean_early: got %0d presses expected 0", press_n[0]); end
        checks++; if (bus.key_state !== 2'b00) begin errors++; $display("[TB] FAIL clean_state_early: got %b expected 00", bus.key_state); end
        run_to(45);
        checks++; if (press_n[0] !== 1) begin errors++; $display("[TB] FAIL clean_count: got %0d presses expected 1", press_n[0]); end
        checks++; if (press_at[0] !== 30) begin errors++; $display("[TB] FAIL clean_time: got cycle %0d expected 30", press_at[0]); end
        checks++; if (press_state[0] !== 1'b1) begin errors++; $display("[TB] FAIL clean_state_with_press: got %b expected 1", press_state[0]); end
        checks++; if (bus.key_state !== 2'b01) begin errors++; $display("[TB] FAIL clean_state: got %b expected 01", bus.key_state); end
        checks++; if (press_n[1] !== 0) begin errors++; $display("[TB] FAIL clean_other: got %0d presses expected 0", press_n[1]); end
    endtask

    task automatic test_bounce();
        hold_reset(2'b11);
        release_reset();
        bus.i_key = 2'b10;
        run_to(20);
        bus.i_key = 2'b11;
        run_to(30);
        bus.i_key = 2'b10;
        run_to(59);
        checks++; if (press_n[0] !== 0) begin errors++; $display("[TB] FAIL bounce_early: got %0d presses expected 0", press_n[0]); end
        run_to(70);
        checks++; if (press_n[0] !== 1) begin errors++; $display("[TB] FAIL bounce_count: got %0d presses expected 1", press_n[0]); end
        checks++; if (press_at[0] !== 60) begin errors++; $display("[TB] FAIL bounce_time: got cycle %0d expected 60", press_at[0]); end
    endtask

    task automatic test_long_press();
        hold_reset(2'b11);
        release_reset();
        bus.i_key = 2'b10;
        run_to(150);
        checks++; if (long_n[0] !== 1) begin errors++; $display("[TB] FAIL long_count: got %0d expected 1", long_n[0]); end
        checks++; if (long_at[0] !== 130) begin errors++; $display("[TB] FAIL long_time: got cycle %0d expected 130", long_at[0]); end
        bus.i_key = 2'b11;
        run_to(160);
        checks++; if (bus.key_state[0] !== 1'b1) begin errors++; $display("[TB] FAIL long_relwait_state: got %b expected 1", bus.key_state[0]); end
        bus.i_key = 2'b10;
        run_to(170);
        bus.i_key = 2'b11;
        run_to(199);
        checks++; if (release_n[0] !== 0) begin errors++; $display("[TB] FAIL long_release_early: got %0d expected 0", release_n[0]); end
        checks++; if (bus.key_state[0] !== 1'b1) begin errors++; $display("[TB] FAIL long_state_held: got %b expected 1", bus.key_state[0]); end
        run_to(215);
        checks++; if (release_n[0] !== 1) begin errors++; $display("[TB] FAIL long_release_count: got %0d expected 1", release_n[0]); end
        checks++; if (release_at[0] !== 200) begin errors++; $display("[TB] FAIL long_release_time: got cycle %0d expected 200", release_at[0]); end
        checks++; if (bus.key_state[0] !== 1'b0) begin errors++; $display("[TB] FAIL long_state_after: got %b expected 0", bus.key_state[0]); end
        checks++; if (long_n[0] !== 1) begin errors++; $display("[TB] FAIL long_rearm: got %0d long pulses expected 1", long_n[0]); end
        checks++; if (press_n[0] !== 1) begin errors++; $display("[TB] FAIL long_press_count: got %0d expected 1", press_n[0]); end
    endtask

    task automatic test_independence_reset();
        hold_reset(2'b11);
        release_reset();
        bus.i_key = 2'b00;
        run_to(35);
        checks++; if (press_at[0] !== 30) begin errors++; $display("[TB] FAIL indep_time0: got cycle %0d expected 30", press_at[0]); end
        checks++; if (press_at[1] !== 30) begin errors++; $display("[TB] FAIL indep_time1: got cycle %0d expected 30", press_at[1]); end
        checks++; if (bus.key_state !== 2'b11) begin errors++; $display("[TB] FAIL indep_state: got %b expected 11", bus.key_state); end
        clear_counts();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.key_state !== 2'b00) begin errors++; $display("[TB] FAIL midreset_state: got %b expected 00", bus.key_state); end
        repeat (4) step();
        checks++; if ((release_n[0] + release_n[1]) !== 0) begin errors++; $display("[TB] FAIL midreset_release: got %0d pulses expected 0", release_n[0] + release_n[1]); end
        release_reset();
        run_to(29);
        checks++; if ((press_n[0] + press_n[1]) !== 0) begin errors++; $display("[TB] FAIL postreset_early: got %0d presses expected 0", press_n[0] + press_n[1]); end
        run_to(40);
        checks++; if (press_at[0] !== 30) begin errors++; $display("[TB] FAIL postreset_time0: got cycle %0d expected 30", press_at[0]); end
        checks++; if (press_at[1] !== 30) begin errors++; $display("[TB] FAIL postreset_time1: got cycle %0d expected 30", press_at[1]); end
        checks++; if ((release_n[0] + release_n[1]) !== 0) begin errors++; $display("[TB] FAIL postreset_release: got %0d expected 0", release_n[0] + release_n[1]); end
    endtask

    task automatic test_glitch();
        hold_reset(2'b11);
        release_reset();
        run_to(11);
        bus.i_key = 2'b10;
        run_to(14);
        bus.i_key = 2'b11;
        run_to(60);
        checks++; if (press_n[0] !== 0) begin errors++; $display("[TB] FAIL glitch_press: got %0d expected 0", press_n[0]); end
        checks++; if (bus.key_state !== 2'b00) begin errors++; $display("[TB] FAIL glitch_state: got %b expected 00", bus.key_state); end
        checks++; if ((release_n[0] + long_n[0]) !== 0) begin errors++; $display("[TB] FAIL glitch_events: got %0d expected 0", release_n[0] + long_n[0]); end
    endtask

    initial begin
        bus.i_key = 2'b11;
        clear_counts();
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_independence_reset();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
